// File: rtl/legv8_control_fsm.sv
// Multi-cycle control unit for the 64-bit LEGv8 datapath: sequences fetch, decode and execute,
// driving every datapath control from the registered state and the instruction register.
module legv8_control_fsm #(
   parameter int RD_WAIT         = 1,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic [31:0] IR,
   input  logic [3:0]  status,
   output logic        w_reg,
   output logic        C0,
   output logic        mem_cs,
   output logic        mem_write_en,
   output logic        IR_load,
   output logic        status_load,
   output logic        B_Sel,
   output logic        PC_sel,
   output logic        add_tri_sel,
   output logic [31:0] k,
   output logic [4:0]  FS,
   output logic [1:0]  PC_FS,
   output logic [1:0]  size,
   output logic [4:0]  SA,
   output logic [4:0]  SB,
   output logic [4:0]  DA,
   output logic [1:0]  data_tri_sel,
   output logic        halted,
   output logic        illegal,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_FWAIT  = 4'd2,
      S_DECODE = 4'd3,
      S_EXEC   = 4'd4,
      S_RD     = 4'd5,
      S_RWAIT  = 4'd6,
      S_WB     = 4'd7,
      S_WR     = 4'd8,
      S_CBTEST = 4'd9,
      S_BRANCH = 4'd10,
      S_HALT   = 4'd11
   } state_t;

   typedef enum logic [3:0] {
      C_NONE, C_ADD, C_SUB, C_AND, C_ORR, C_EOR, C_ADDI, C_SUBI,
      C_LDUR, C_STUR, C_B, C_CBZ, C_CBNZ, C_ZERO, C_ILL
   } cls_t;

   localparam logic [4:0] FS_AND = 5'b00000;
   localparam logic [4:0] FS_ORR = 5'b00100;
   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_SUB = 5'b01010;
   localparam logic [4:0] FS_EOR = 5'b01100;

   // Counter preload: the cycle that loads it is itself the first of RD_WAIT+1 read cycles.
   localparam logic [2:0] WAIT_LOAD = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;

   state_t      r_state;
   state_t      w_next;
   cls_t        r_cls;
   cls_t        w_dec_cls;
   logic [2:0]  r_cnt;
   logic [2:0]  w_cnt_next;
   logic        r_illegal;
   logic        w_taken;
   logic        w_is_imm;
   logic [31:0] w_b_off;
   logic [31:0] w_cb_off;
   logic [31:0] w_mem_off;
   logic [31:0] w_alu_imm;
   logic        w_unused_status;

   function automatic logic [4:0] alu_fs(input cls_t c);
      case (c)
         C_AND:          return FS_AND;
         C_ORR:          return FS_ORR;
         C_EOR:          return FS_EOR;
         C_SUB, C_SUBI:  return FS_SUB;
         default:        return FS_ADD;
      endcase
   endfunction

   assign w_unused_status = ^status[3:1];

   always_comb begin
      w_dec_cls = C_ILL;
      if (IR == 32'd0)                        w_dec_cls = C_ZERO;
      else if (IR[31:21] == 11'b10001011000)  w_dec_cls = C_ADD;
      else if (IR[31:21] == 11'b11001011000)  w_dec_cls = C_SUB;
      else if (IR[31:21] == 11'b10001010000)  w_dec_cls = C_AND;
      else if (IR[31:21] == 11'b10101010000)  w_dec_cls = C_ORR;
      else if (IR[31:21] == 11'b11001010000)  w_dec_cls = C_EOR;
      else if (IR[31:22] == 10'b1001000100)   w_dec_cls = C_ADDI;
      else if (IR[31:22] == 10'b1101000100)   w_dec_cls = C_SUBI;
      else if (IR[31:21] == 11'b11111000010)  w_dec_cls = C_LDUR;
      else if (IR[31:21] == 11'b11111000000)  w_dec_cls = C_STUR;
      else if (IR[31:26] == 6'b000101)        w_dec_cls = C_B;
      else if (IR[31:24] == 8'b10110100)      w_dec_cls = C_CBZ;
      else if (IR[31:24] == 8'b10110101)      w_dec_cls = C_CBNZ;
   end

   // Branch offsets are relative to the already-incremented PC, hence the -4.
   assign w_b_off   = ({{6{IR[25]}}, IR[25:0]} << 2) - 32'd4;
   assign w_cb_off  = ({{13{IR[23]}}, IR[23:5]} << 2) - 32'd4;
   assign w_mem_off = {{23{IR[20]}}, IR[20:12]};
   assign w_alu_imm = {20'd0, IR[21:10]};
   assign w_is_imm  = (r_cls == C_ADDI) || (r_cls == C_SUBI);
   assign w_taken   = (r_cls == C_B) ||
                      ((r_cls == C_CBZ) && status[0]) ||
                      ((r_cls == C_CBNZ) && !status[0]);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cls     <= C_NONE;
         r_cnt     <= 3'd0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (r_state == S_DECODE) begin
            r_cls <= w_dec_cls;
            if (w_dec_cls == C_ILL) r_illegal <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next       = r_state;
      w_cnt_next   = r_cnt;
      w_reg        = 1'b0;
      C0           = 1'b0;
      mem_cs       = 1'b0;
      mem_write_en = 1'b0;
      IR_load      = 1'b0;
      status_load  = 1'b0;
      B_Sel        = 1'b0;
      PC_sel       = 1'b0;
      add_tri_sel  = 1'b1;
      k            = 32'd0;
      FS           = 5'd0;
      PC_FS        = 2'b00;
      size         = 2'b11;
      SA           = 5'd0;
      SB           = 5'd0;
      DA           = 5'd0;
      data_tri_sel = 2'b00;
      halted       = 1'b0;

      // Loads and stores share the base+offset address path through the ALU.
      if (r_state inside {S_RD, S_RWAIT, S_WB, S_WR}) begin
         SA           = IR[9:5];
         B_Sel        = 1'b1;
         k            = w_mem_off;
         FS           = FS_ADD;
         add_tri_sel  = 1'b0;
         mem_cs       = 1'b1;
         data_tri_sel = 2'b11;
      end

      case (r_state)
         S_IDLE: begin
            if (run) w_next = S_FETCH;
         end
         S_FETCH, S_FWAIT: begin
            mem_cs       = 1'b1;
            data_tri_sel = 2'b11;
            if ((r_state == S_FETCH && RD_WAIT == 0) || (r_state == S_FWAIT && r_cnt == 3'd0)) begin
               IR_load = 1'b1;
               PC_FS   = 2'b01;
               w_next  = S_DECODE;
            end else if (r_state == S_FETCH) begin
               w_cnt_next = WAIT_LOAD;
               w_next     = S_FWAIT;
            end else begin
               w_cnt_next = r_cnt - 3'd1;
            end
         end
         S_DECODE: begin
            case (w_dec_cls)
               C_ADD, C_SUB, C_AND, C_ORR, C_EOR, C_ADDI, C_SUBI: w_next = S_EXEC;
               C_LDUR:        w_next = S_RD;
               C_STUR:        w_next = S_WR;
               C_B:           w_next = S_BRANCH;
               C_CBZ, C_CBNZ: w_next = S_CBTEST;
               C_ZERO:        w_next = S_HALT;
               default:       w_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
            endcase
         end
         S_EXEC: begin
            SA           = IR[9:5];
            SB           = IR[20:16];
            DA           = IR[4:0];
            B_Sel        = w_is_imm;
            k            = w_alu_imm;
            FS           = alu_fs(r_cls);
            C0           = (r_cls == C_SUB) || (r_cls == C_SUBI);
            data_tri_sel = 2'b00;
            w_reg        = (IR[4:0] != 5'd31);
            w_next       = run ? S_FETCH : S_IDLE;
         end
         S_RD, S_RWAIT: begin
            if ((r_state == S_RD && RD_WAIT == 0) || (r_state == S_RWAIT && r_cnt == 3'd0)) begin
               w_next = S_WB;
            end else if (r_state == S_RD) begin
               w_cnt_next = WAIT_LOAD;
               w_next     = S_RWAIT;
            end else begin
               w_cnt_next = r_cnt - 3'd1;
            end
         end
         S_WB: begin
            DA     = IR[4:0];
            w_reg  = (IR[4:0] != 5'd31);
            w_next = run ? S_FETCH : S_IDLE;
         end
         S_WR: begin
            SB           = IR[4:0];
            data_tri_sel = 2'b01;
            mem_write_en = 1'b1;
            w_next       = run ? S_FETCH : S_IDLE;
         end
         S_CBTEST: begin
            SA          = IR[4:0];
            B_Sel       = 1'b1;
            FS          = FS_ORR;
            status_load = 1'b1;
            w_next      = S_BRANCH;
         end
         S_BRANCH: begin
            if (w_taken) begin
               PC_sel = 1'b1;
               PC_FS  = 2'b10;
               k      = (r_cls == C_B) ? w_b_off : w_cb_off;
            end
            w_next = run ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign illegal = r_illegal;
   assign state   = r_state;

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Bench for legv8_control_fsm: directed table, hand-written corner sequences, and random
// instructions checked cycle-by-cycle against an instruction-level trace model.
module tb_legv8_control_fsm;
   localparam int RD_WAIT = 1;

   logic        clock = 1'b0;
   logic        reset, run;
   logic [31:0] IR;
   logic [3:0]  status;
   logic        w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, B_Sel, PC_sel, add_tri_sel;
   logic [31:0] k;
   logic [4:0]  FS, SA, SB, DA;
   logic [1:0]  PC_FS, size, data_tri_sel;
   logic        halted, illegal;
   logic [3:0]  state;

   legv8_control_fsm #(.RD_WAIT(RD_WAIT), .HALT_ON_ILLEGAL(1'b1)) dut (
      .clock(clock), .reset(reset), .run(run), .IR(IR), .status(status),
      .w_reg(w_reg), .C0(C0), .mem_cs(mem_cs), .mem_write_en(mem_write_en), .IR_load(IR_load),
      .status_load(status_load), .B_Sel(B_Sel), .PC_sel(PC_sel), .add_tri_sel(add_tri_sel),
      .k(k), .FS(FS), .PC_FS(PC_FS), .size(size), .SA(SA), .SB(SB), .DA(DA),
      .data_tri_sel(data_tri_sel), .halted(halted), .illegal(illegal), .state(state)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, B_Sel, PC_sel, add_tri_sel;
      logic [31:0] k;
      logic [4:0]  FS;
      logic [1:0]  PC_FS, size;
      logic [4:0]  SA, SB, DA;
      logic [1:0]  data_tri_sel;
      logic        halted, illegal;
   } ctl_t;

   typedef struct {
      logic [31:0] ir;
      logic [3:0]  st;
      logic [31:0] k;
      logic [4:0]  fs;
      logic        c0, w, bsel, mwe;
      logic [4:0]  sa, sb, da;
      logic [1:0]  pcfs, dts;
      int          lat;
      string       nm;
   } vec_t;

   localparam int K_AND = 0, K_ORR = 1, K_ADD = 2, K_EOR = 3, K_SUB = 4, K_ADDI = 5, K_SUBI = 6;
   localparam int K_LDUR = 7, K_STUR = 8, K_B = 9, K_CBZ = 10, K_CBNZ = 11, K_ZERO = 12, K_ILL = 13;

   int         errors = 0;
   int         checks = 0;
   logic [3:0] idle_st;
   ctl_t       exp_q[$];
   ctl_t       exp_end;
   bit         exp_halt;
   vec_t       tbl[17];

   task automatic check(input string nm, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic ctl_t snap();
      ctl_t s;
      s.w_reg = w_reg; s.C0 = C0; s.mem_cs = mem_cs; s.mem_write_en = mem_write_en;
      s.IR_load = IR_load; s.status_load = status_load; s.B_Sel = B_Sel; s.PC_sel = PC_sel;
      s.add_tri_sel = add_tri_sel; s.k = k; s.FS = FS; s.PC_FS = PC_FS; s.size = size;
      s.SA = SA; s.SB = SB; s.DA = DA; s.data_tri_sel = data_tri_sel;
      s.halted = halted; s.illegal = illegal;
      return s;
   endfunction

   function automatic ctl_t idle_rec(input logic ill);
      ctl_t r;
      r = '0;
      r.add_tri_sel = 1'b1;
      r.size        = 2'b11;
      r.illegal     = ill;
      return r;
   endfunction

   function automatic int cls(input logic [31:0] ir);
      if (ir == 32'd0) return K_ZERO;
      case (ir[31:21])
         11'b10001011000: return K_ADD;
         11'b11001011000: return K_SUB;
         11'b10001010000: return K_AND;
         11'b10101010000: return K_ORR;
         11'b11001010000: return K_EOR;
         11'b11111000010: return K_LDUR;
         11'b11111000000: return K_STUR;
         default: ;
      endcase
      if (ir[31:22] == 10'b1001000100) return K_ADDI;
      if (ir[31:22] == 10'b1101000100) return K_SUBI;
      if (ir[31:26] == 6'b000101)      return K_B;
      if (ir[31:24] == 8'b10110100)    return K_CBZ;
      if (ir[31:24] == 8'b10110101)    return K_CBNZ;
      return K_ILL;
   endfunction

   // Expected per-cycle outputs from the first FETCH cycle to the last cycle of the instruction.
   function automatic void build(input logic [31:0] ir, input logic [3:0] st);
      ctl_t       r;
      int         c;
      bit         taken, sub;
      logic [2:0] op;
      longint     off;
      exp_q.delete();
      exp_halt = 1'b0;
      exp_end  = idle_rec(1'b0);
      for (int i = 0; i <= RD_WAIT; i++) begin
         r = idle_rec(1'b0);
         r.mem_cs = 1'b1;
         r.data_tri_sel = 2'b11;
         if (i == RD_WAIT) begin
            r.IR_load = 1'b1;
            r.PC_FS = 2'b01;
         end
         exp_q.push_back(r);
      end
      exp_q.push_back(idle_rec(1'b0));
      c = cls(ir);
      if (c <= K_SUBI) begin
         op  = (c == K_AND) ? 3'd0 : (c == K_ORR) ? 3'd1 : (c == K_EOR) ? 3'd3 : 3'd2;
         sub = (c == K_SUB) || (c == K_SUBI);
         r = idle_rec(1'b0);
         r.SA = ir[9:5]; r.SB = ir[20:16]; r.DA = ir[4:0];
         r.B_Sel = (c == K_ADDI) || (c == K_SUBI);
         r.k = {20'd0, ir[21:10]};
         r.FS = {op, sub, 1'b0};
         r.C0 = sub;
         r.w_reg = (ir[4:0] != 5'd31);
         exp_q.push_back(r);
      end else if (c == K_LDUR || c == K_STUR) begin
         r = idle_rec(1'b0);
         r.SA = ir[9:5]; r.B_Sel = 1'b1;
         r.k = 32'(longint'($signed(ir[20:12])));
         r.FS = 5'b01000; r.add_tri_sel = 1'b0; r.mem_cs = 1'b1; r.data_tri_sel = 2'b11;
         if (c == K_LDUR) begin
            for (int i = 0; i <= RD_WAIT; i++) exp_q.push_back(r);
            r.DA = ir[4:0];
            r.w_reg = (ir[4:0] != 5'd31);
         end else begin
            r.SB = ir[4:0]; r.data_tri_sel = 2'b01; r.mem_write_en = 1'b1;
         end
         exp_q.push_back(r);
      end else if (c == K_B || c == K_CBZ || c == K_CBNZ) begin
         if (c != K_B) begin
            r = idle_rec(1'b0);
            r.SA = ir[4:0]; r.B_Sel = 1'b1; r.FS = 5'b00100; r.status_load = 1'b1;
            exp_q.push_back(r);
         end
         taken = (c == K_B) || (c == K_CBZ && st[0]) || (c == K_CBNZ && !st[0]);
         off = (c == K_B) ? longint'($signed(ir[25:0])) : longint'($signed(ir[23:5]));
         r = idle_rec(1'b0);
         if (taken) begin
            r.PC_sel = 1'b1;
            r.PC_FS = 2'b10;
            r.k = 32'(off * 4 - 4);
         end
         exp_q.push_back(r);
      end else begin
         exp_halt = 1'b1;
         exp_end = idle_rec(c == K_ILL);
         exp_end.halted = 1'b1;
      end
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("reset_values", snap(), idle_rec(1'b0));
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic run_model(input logic [31:0] ir, input logic [3:0] st);
      build(ir, st);
      IR = ir; status = st; run = 1'b1;
      check("idle_before", snap(), idle_rec(1'b0));
      @(negedge clock);
      run = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("trace ir=%h cyc%0d", ir, i), snap(), exp_q[i]);
         @(negedge clock);
      end
      check($sformatf("end ir=%h", ir), snap(), exp_end);
      if (exp_halt) begin
         run = 1'b1;
         repeat (3) @(negedge clock);
         check("halt_hold", snap(), exp_end);
         run = 1'b0;
         do_reset();
      end
   endtask

   task automatic run_capture(input logic [31:0] ir, input logic [3:0] st, output ctl_t last, output int n);
      IR = ir; status = st; run = 1'b1;
      @(negedge clock);
      run = 1'b0;
      n = 0;
      last = snap();
      while (state != idle_st && n < 50) begin
         last = snap();
         n++;
         @(negedge clock);
      end
   endtask

   function automatic logic [31:0] rand_ir();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r[4:0] = 5'd31;
      case ($urandom_range(0, 14))
         0:  r[31:21] = 11'b10001011000;
         1:  r[31:21] = 11'b11001011000;
         2:  r[31:21] = 11'b10001010000;
         3:  r[31:21] = 11'b10101010000;
         4:  r[31:21] = 11'b11001010000;
         5:  r[31:22] = 10'b1001000100;
         6:  r[31:22] = 10'b1101000100;
         7:  r[31:21] = 11'b11111000010;
         8:  r[31:21] = 11'b11111000000;
         9:  r[31:26] = 6'b000101;
         10: r[31:24] = 8'b10110100;
         11: r[31:24] = 8'b10110101;
         12: r = 32'd0;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      ctl_t last;
      int   n;
      bit   seen;

      tbl[0]  = '{32'h8B020023, 4'h0, 32'h080, 5'b01000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 2'b00, 4, "add"};
      tbl[1]  = '{32'hCB020023, 4'h0, 32'h080, 5'b01010, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 2'b00, 4, "sub"};
      tbl[2]  = '{32'h8A030041, 4'h0, 32'h0C0, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 5'd3, 5'd1, 2'b00, 2'b00, 4, "and"};
      tbl[3]  = '{32'hAA030041, 4'h0, 32'h0C0, 5'b00100, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 5'd3, 5'd1, 2'b00, 2'b00, 4, "orr"};
      tbl[4]  = '{32'hCA030041, 4'h0, 32'h0C0, 5'b01100, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 5'd3, 5'd1, 2'b00, 2'b00, 4, "eor"};
      tbl[5]  = '{32'h9100141F, 4'h0, 32'h005, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd31, 2'b00, 2'b00, 4, "addi_xzr"};
      tbl[6]  = '{32'hD13FFC62, 4'h0, 32'hFFF, 5'b01010, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd31, 5'd2, 2'b00, 2'b00, 4, "subi_max"};
      tbl[7]  = '{32'hF85F80A4, 4'h0, 32'hFFFFFFF8, 5'b01000, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd4, 2'b00, 2'b11, 0, "ldur_neg"};
      tbl[8]  = '{32'hF85F80BF, 4'h0, 32'hFFFFFFF8, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd31, 2'b00, 2'b11, 0, "ldur_xzr"};
      tbl[9]  = '{32'hF8010049, 4'h0, 32'h010, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 5'd9, 5'd0, 2'b00, 2'b01, 4, "stur"};
      tbl[10] = '{32'hB4000067, 4'h1, 32'h008, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 2'b00, 5, "cbz_taken"};
      tbl[11] = '{32'hB4000067, 4'h0, 32'h000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 5, "cbz_not"};
      tbl[12] = '{32'hB5000067, 4'h0, 32'h008, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 2'b00, 5, "cbnz_taken"};
      tbl[13] = '{32'hB5000067, 4'hF, 32'h000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 5, "cbnz_not"};
      tbl[14] = '{32'h17FFFFFF, 4'h0, 32'hFFFFFFF8, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 2'b00, 4, "b_back"};
      tbl[15] = '{32'h14000010, 4'h0, 32'h03C, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 2'b00, 4, "b_fwd"};
      tbl[16] = '{32'hCB02003F, 4'h0, 32'h080, 5'b01010, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd31, 2'b00, 2'b00, 4, "sub_xzr"};

      reset = 1'b1; run = 1'b0; IR = 32'd0; status = 4'd0;
      repeat (2) @(negedge clock);
      check("reset_state", snap(), idle_rec(1'b0));
      reset = 1'b0;
      idle_st = state;
      @(negedge clock);
      check("idle_no_run", snap(), idle_rec(1'b0));

      for (int i = 0; i < 17; i++) begin
         run_capture(tbl[i].ir, tbl[i].st, last, n);
         check(tbl[i].nm,
               {last.k, last.FS, last.C0, last.w_reg, last.B_Sel, last.mem_write_en,
                last.SA, last.SB, last.DA, last.PC_FS, last.data_tri_sel},
               {tbl[i].k, tbl[i].fs, tbl[i].c0, tbl[i].w, tbl[i].bsel, tbl[i].mwe,
                tbl[i].sa, tbl[i].sb, tbl[i].da, tbl[i].pcfs, tbl[i].dts});
         if (tbl[i].lat != 0) check({tbl[i].nm, "_latency"}, 80'(n), 80'(tbl[i].lat));
      end

      // Reset asserted while the store strobe is active.
      IR = 32'hF8010049; run = 1'b1;
      @(negedge clock);
      run = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (mem_write_en) seen = 1'b1;
         else @(negedge clock);
      end
      check("wr_reached", 80'(seen), 80'd1);
      reset = 1'b1;
      #1;
      check("reset_in_wr", {mem_write_en, w_reg, illegal, add_tri_sel, size, (state == idle_st)},
            {1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1});
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("after_wr_reset", snap(), idle_rec(1'b0));

      // run held high: EXEC is followed directly by the next FETCH.
      IR = 32'h8B020023; run = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         if (w_reg) seen = 1'b1;
      end
      check("b2b_exec_seen", 80'(seen), 80'd1);
      @(negedge clock);
      check("b2b_refetch", {mem_cs, data_tri_sel, add_tri_sel}, {1'b1, 2'b11, 1'b1});
      run = 1'b0;
      n = 0;
      while (state != idle_st && n < 50) begin
         n++;
         @(negedge clock);
      end
      check("b2b_finish_len", 80'(n), 80'(RD_WAIT + 3));

      // Undecodable opcode halts and stays halted with run high until reset.
      IR = 32'hFFFFFFFF; run = 1'b1;
      repeat (12) @(negedge clock);
      check("illegal_halt", {halted, illegal}, 2'b11);
      run = 1'b0;
      do_reset();
      check("illegal_cleared", {halted, illegal}, 2'b00);

      for (int i = 0; i < 120; i++) run_model(rand_ir(), 4'($urandom_range(0, 15)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
